// File: rtl/subtractor_serial_if.sv
// Handshake and data bundle for subtractor_serial.
//   start     - request a subtraction (master -> slave)
//   a, b      - minuend / subtrahend (master -> slave)
//   out       - difference a - b mod 2^WIDTH (slave -> master)
//   busy      - operation in progress (slave -> master)
//   done      - one-cycle pulse, results newly valid (slave -> master)
//   borrow, zero, neg, ovf - result flags (slave -> master)
interface subtractor_serial_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             borrow;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, a, b,
    input  out, busy, done, borrow, zero, neg, ovf
  );

  modport slave (
    input  start, a, b,
    output out, busy, done, borrow, zero, neg, ovf
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first.
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   io_bus - subtractor_serial_if slave: start/a/b in; out/busy/done and
//            borrow/zero/neg/ovf flags out.
// Results and flags are registered and only change on entry to DONE.
module subtractor_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  subtractor_serial_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CntW-1:0]  r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  logic w_accept;
  logic w_last;
  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_bout;

  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_d    = w_ai ^ w_bi ^ r_bin;
  assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);

  // All WIDTH bits have been shifted in; this RUN cycle commits the result.
  assign w_last   = (r_cnt == CntW'(WIDTH));
  assign w_accept = io_bus.start && (r_state != StRun);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = io_bus.start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_out    <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= io_bus.a;
      r_b     <= io_bus.b;
      r_a_msb <= io_bus.a[WIDTH-1];
      r_b_msb <= io_bus.b[WIDTH-1];
      r_res   <= '0;
      r_bin   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == StRun) begin
      if (w_last) begin
        r_out    <= r_res;
        r_borrow <= r_bin;
        r_zero   <= (r_res == '0);
        r_neg    <= r_res[WIDTH-1];
        // Operand MSBs are kept aside since the shift registers lose them.
        r_ovf    <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
      end else begin
        r_a   <= {1'b0, r_a[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_res <= {w_d, r_res[WIDTH-1:1]};
        r_bin <= w_bout;
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  // Decoded straight from the state so reset clears them without a clock edge.
  assign io_bus.busy   = (r_state == StRun);
  assign io_bus.done   = (r_state == StDone);
  assign io_bus.out    = r_out;
  assign io_bus.borrow = r_borrow;
  assign io_bus.zero   = r_zero;
  assign io_bus.neg    = r_neg;
  assign io_bus.ovf    = r_ovf;

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboard bench for subtractor_serial: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares whenever done is high.
module tb_subtractor_serial;

  localparam int unsigned W = 16;
  localparam int unsigned Lat = 18;  // posedges from issue stamp to done visible

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  subtractor_serial_if #(.WIDTH(W)) bus ();

  subtractor_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic [W-1:0] out;
    logic         borrow;
    logic         zero;
    logic         neg;
    logic         ovf;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int unsigned pcnt  = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) pcnt <= pcnt + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out",     {16'b0, bus.out},   {16'b0, e.out});
        check("borrow",  {31'b0, bus.borrow}, {31'b0, e.borrow});
        check("zero",    {31'b0, bus.zero},   {31'b0, e.zero});
        check("neg",     {31'b0, bus.neg},    {31'b0, e.neg});
        check("ovf",     {31'b0, bus.ovf},    {31'b0, e.ovf});
        check("latency", pcnt,                e.due);
        check("busy_in_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  // Drive start for one cycle. With now=1 the call is already inside a cycle
  // (posedge+2) and drives immediately, e.g. during the DONE cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eo, input logic eb, input logic ez,
                       input logic en, input logic ev, input bit now,
                       input bit expect_it);
    exp_t e;
    if (!now) begin
      @(posedge clk);
      #2;
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    if (expect_it) begin
      e.out = eo; e.borrow = eb; e.zero = ez; e.neg = en; e.ovf = ev;
      e.due = pcnt + Lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Returns at posedge+2 inside the DONE cycle, or flags a timeout.
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (bus.done) return;
    end
    check("done_timeout", {31'b0, bus.done}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   {31'b0, bus.busy},   32'd0);
    check({tag, "_done"},   {31'b0, bus.done},   32'd0);
    check({tag, "_out"},    {16'b0, bus.out},    32'd0);
    check({tag, "_borrow"}, {31'b0, bus.borrow}, 32'd0);
    check({tag, "_zero"},   {31'b0, bus.zero},   32'd0);
    check({tag, "_neg"},    {31'b0, bus.neg},    32'd0);
    check({tag, "_ovf"},    {31'b0, bus.ovf},    32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check_all_zero("reset");

    // start held while in reset must be ignored
    bus.start = 1'b1;
    bus.a     = 16'h0005;
    bus.b     = 16'h0003;
    repeat (2) @(posedge clk);
    #2;
    check("start_in_reset_busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    #1 rst = 1'b0;

    issue(16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0, 0, 1);
    wait_done();
    issue(16'h0003, 16'h0005, 16'hFFFE, 1, 0, 1, 0, 0, 1);
    wait_done();
    issue(16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0, 1);
    wait_done();
    issue(16'h1234, 16'h1234, 16'h0000, 0, 1, 0, 0, 0, 1);
    wait_done();

    // start during RUN cycle 5 is ignored; outputs hold the previous result
    issue(16'h00FF, 16'h000F, 16'h00F0, 0, 0, 0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #2;
    check("hold_out_in_run",  {16'b0, bus.out},  32'h0000);
    check("hold_zero_in_run", {31'b0, bus.zero}, 32'd1);
    check("busy_in_run",      {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_done();

    // back-to-back: start in the DONE cycle
    issue(16'h0001, 16'h8000, 16'h8001, 1, 0, 1, 1, 1, 1);
    check("busy_after_b2b", {31'b0, bus.busy}, 32'd1);
    wait_done();

    // abort at RUN cycle 8 with an asynchronous reset
    issue(16'h7FFF, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (25) @(posedge clk);

    issue(16'h0010, 16'h0001, 16'h000F, 0, 0, 0, 0, 0, 1);
    wait_done();
    issue(16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1, 0, 0, 1);
    wait_done();
    issue(16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1, 1, 0, 1);
    wait_done();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    check("queue_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
